// File: rtl/r7_uart_reporter.sv
// rtl/r7_uart_reporter.sv - reports each new r7 value from the core as two 8N1 UART bytes
//
// Watches r7_data for changes, holds the newest value in a one-deep capture
// register and sends it on tx as two 8N1 bytes, high byte first.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   r7_data     r7 value from the CPU core (same clock domain)
//   tx          UART serial out, idle high, driven from a flop
//   busy        high while a two-byte frame is on the line
//   pending     capture register holds a value not yet started
//   drop_count  captured values overwritten before being sent (saturating)
module r7_uart_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DROP_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           r7_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  pending,
  output logic [DROP_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_next;
  logic [15:0] last_seen, cap_val, shift_word;
  logic [15:0] baud_cnt, baud_cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        byte_hi, byte_hi_next;
  logic        capture, load, baud_done;
  logic        tx_next, busy_next;
  logic [15:0] word_next;
  logic [7:0]  byte_next;

  assign capture   = (r7_data != last_seen);
  assign load      = (state == S_IDLE) && pending;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic, including the bit timing counters
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    byte_hi_next  = byte_hi;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_next    = S_START;
          baud_cnt_next = 16'd0;
          bit_idx_next  = 3'd0;
          byte_hi_next  = 1'b1;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_next    = S_DATA;
          baud_cnt_next = 16'd0;
          bit_idx_next  = 3'd0;
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_cnt_next = 16'd0;
          if (bit_idx == 3'd7) state_next   = S_STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_cnt_next = 16'd0;
          // High byte chains straight into the low byte's start bit
          if (byte_hi) begin
            state_next   = S_START;
            byte_hi_next = 1'b0;
          end else begin
            state_next   = S_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: tx and busy are computed from the next state so their
  // flops present the new line level in the same cycle the state changes.
  always_comb begin
    word_next = load ? cap_val : shift_word;
    byte_next = byte_hi_next ? word_next[15:8] : word_next[7:0];
    busy_next = (state_next != S_IDLE);
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = byte_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  // Datapath and output flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      byte_hi    <= 1'b1;
      shift_word <= 16'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      last_seen  <= 16'd0;
      cap_val    <= 16'd0;
      pending    <= 1'b0;
      drop_count <= '0;
    end else begin
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      byte_hi  <= byte_hi_next;
      tx       <= tx_next;
      busy     <= busy_next;
      // A load always takes the value held before any same-cycle capture
      if (load) shift_word <= cap_val;
      // Capture sets pending even when a load clears it in the same cycle
      if (capture) begin
        last_seen <= r7_data;
        cap_val   <= r7_data;
        pending   <= 1'b1;
      end else if (load) begin
        pending   <= 1'b0;
      end
      if (capture && pending && !load && (drop_count != {DROP_WIDTH{1'b1}}))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
